// File: rtl/cdb_writeback_scheduler_pkg.sv
// Defaults for the CDB writeback scheduler.
//   CDB_QDEPTH       : entries per FU completion queue (power of two, >= 2)
//   CDB_STARVE_LIMIT : wait cycles before a queue head is forced onto the bus
package cdb_writeback_scheduler_pkg;
    localparam int CDB_QDEPTH       = 2;
    localparam int CDB_STARVE_LIMIT = 8;
endpackage

// File: rtl/rv32i_types.sv
// Shared core types.
//   TOTAL_FU    : number of functional units that complete onto the CDB
//   cdb_entry_t : payload broadcast on the Common Data Bus
package rv32i_types;
    localparam int TOTAL_FU = 5;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] value;
    } cdb_entry_t;
endpackage

// File: rtl/cdb_writeback_scheduler_fu_queue.sv
// Per-FU completion FIFO with a head wait counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data (caller guarantees !full)
//   pop        : head was granted the CDB this cycle
//   hold       : CDB stalled; wait counter freezes
//   full/empty : occupancy flags
//   head       : oldest entry
//   starved    : head has waited STARVE_LIMIT arbitration cycles
module cdb_fu_queue
    import rv32i_types::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  cdb_entry_t push_data,
    input  logic       pop,
    input  logic       hold,
    output logic       full,
    output logic       empty,
    output cdb_entry_t head,
    output logic       starved
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(STARVE_LIMIT + 1);

    cdb_entry_t    mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [WW-1:0] wait_cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign starved = (wait_cnt == WW'(STARVE_LIMIT));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Payload storage carries no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            wait_cnt <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A popped head is replaced by a fresh one, so the count restarts.
            if (empty || do_pop) begin
                wait_cnt <= '0;
            end else if (!hold && !starved) begin
                wait_cnt <= wait_cnt + WW'(1);
            end
        end
    end
endmodule

// File: rtl/cdb_writeback_scheduler.sv
// Buffers FU completions and schedules one per cycle onto the CDB.
//   clk, rst_n          : clock, asynchronous active-low reset
//   fu_req_valid/data   : FU completion request and payload (per FU)
//   fu_req_ready        : queue can accept (transfer on valid && ready)
//   cdb_hold            : scoreboard stall, no pop this cycle
//   cdb_valid/data/src  : registered broadcast and its source FU index
module cdb_writeback_scheduler
    import rv32i_types::*;
    import cdb_writeback_scheduler_pkg::*;
#(
    parameter int NUM_FU       = TOTAL_FU,
    parameter int QDEPTH       = CDB_QDEPTH,
    parameter int STARVE_LIMIT = CDB_STARVE_LIMIT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_FU-1:0]         fu_req_valid,
    input  cdb_entry_t                fu_req_data [NUM_FU],
    output logic [NUM_FU-1:0]         fu_req_ready,
    input  logic                      cdb_hold,
    output logic                      cdb_valid,
    output cdb_entry_t                cdb_data,
    output logic [$clog2(NUM_FU)-1:0] cdb_src
);
    localparam int SW = $clog2(NUM_FU);

    logic [NUM_FU-1:0] full;
    logic [NUM_FU-1:0] empty;
    logic [NUM_FU-1:0] starved;
    logic [NUM_FU-1:0] pop;
    cdb_entry_t        head [NUM_FU];
    logic [SW-1:0]     rr_ptr;
    logic [SW-1:0]     winner;
    logic              grant;
    int                rr_idx;

    for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
        assign fu_req_ready[g] = !full[g] && rst_n;

        cdb_fu_queue #(
            .DEPTH        (QDEPTH),
            .STARVE_LIMIT (STARVE_LIMIT)
        ) u_queue (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (fu_req_valid[g] && fu_req_ready[g]),
            .push_data (fu_req_data[g]),
            .pop       (pop[g]),
            .hold      (cdb_hold),
            .full      (full[g]),
            .empty     (empty[g]),
            .head      (head[g]),
            .starved   (starved[g])
        );
    end

    // Loops run from the highest index/offset down so the last match
    // (lowest index, or nearest to rr_ptr) is the one that sticks.
    always_comb begin
        grant  = 1'b0;
        winner = '0;
        rr_idx = 0;
        if (!cdb_hold) begin
            for (int i = NUM_FU - 1; i >= 0; i--) begin
                if (starved[i] && !empty[i]) begin
                    grant  = 1'b1;
                    winner = SW'(i);
                end
            end
            if (!grant) begin
                for (int i = NUM_FU - 1; i >= 0; i--) begin
                    rr_idx = (int'(rr_ptr) + i) % NUM_FU;
                    if (!empty[SW'(rr_idx)]) begin
                        grant  = 1'b1;
                        winner = SW'(rr_idx);
                    end
                end
            end
        end
    end

    always_comb begin
        pop = '0;
        if (grant) pop[winner] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
            cdb_data  <= '0;
            cdb_src   <= '0;
        end else begin
            cdb_valid <= grant;
            if (grant) begin
                cdb_data <= head[winner];
                cdb_src  <= winner;
                rr_ptr   <= (winner == SW'(NUM_FU - 1)) ? '0 : winner + SW'(1);
            end
        end
    end
endmodule

// File: tb/tb_cdb_writeback_scheduler.sv
module tb_cdb_writeback_scheduler;
    import rv32i_types::*;

    localparam int N  = 5;
    localparam int QD = 2;
    localparam int SL = 3;

    typedef struct packed {
        logic [2:0] src;
        cdb_entry_t data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  fu_req_valid = '0;
    cdb_entry_t    fu_req_data [N];
    logic [N-1:0]  fu_req_ready;
    logic          cdb_hold = 1'b0;
    logic          cdb_valid;
    cdb_entry_t    cdb_data;
    logic [2:0]    cdb_src;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    cdb_writeback_scheduler #(
        .NUM_FU       (N),
        .QDEPTH       (QD),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fu_req_valid (fu_req_valid),
        .fu_req_data  (fu_req_data),
        .fu_req_ready (fu_req_ready),
        .cdb_hold     (cdb_hold),
        .cdb_valid    (cdb_valid),
        .cdb_data     (cdb_data),
        .cdb_src      (cdb_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic cdb_entry_t mk(input logic [4:0] rd, input logic [31:0] v);
        cdb_entry_t e;
        e.rd    = rd;
        e.value = v;
        return e;
    endfunction

    function automatic void sb_push(input int src, input cdb_entry_t d);
        exp_t e;
        e.src  = 3'(src);
        e.data = d;
        exp_q.push_back(e);
    endfunction

    // Scoreboard monitor: every broadcast must match the next expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (cdb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_bcast actual src=%0d data=%0h required no broadcast",
                         cdb_src, cdb_data);
            end else begin
                e = exp_q.pop_front();
                check("bcast_src", 64'(cdb_src), 64'(e.src));
                check("bcast_data", 64'(cdb_data), 64'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        tick();
        tick();
    endtask

    task automatic burst(input logic [31:0] base);
        for (int i = 0; i < N; i++) begin
            fu_req_valid[i] = 1'b1;
            fu_req_data[i]  = mk(5'(i + 1), base + 32'(i));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int  a_n;
        int  b_n;
        logic acc0;
        logic acc1;
        logic accepted;

        for (int i = 0; i < N; i++) fu_req_data[i] = '0;

        // Reset state
        #1;
        check("rst_valid", 64'(cdb_valid), 64'd0);
        check("rst_src", 64'(cdb_src), 64'd0);
        check("rst_data", 64'(cdb_data), 64'd0);
        check("rst_ready", 64'(fu_req_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_ready", 64'(fu_req_ready), 64'h1f);
        tick();

        // All-FU burst from rr_ptr=0: 0,1,2,3,4 back to back
        burst(32'h100);
        for (int i = 0; i < N; i++) sb_push(i, mk(5'(i + 1), 32'h100 + 32'(i)));
        tick();
        fu_req_valid = '0;
        for (int k = 0; k < N; k++) begin
            tick();
            check("burst1_consec_valid", 64'(cdb_valid), 64'd1);
        end
        drain("burst1_drained", 10);

        // Single FU2 uncontended: visible after the second edge, then gone
        fu_req_valid[2] = 1'b1;
        fu_req_data[2]  = mk(5'd5, 32'h1234);
        sb_push(2, mk(5'd5, 32'h1234));
        tick();
        fu_req_valid[2] = 1'b0;
        check("single_no_bypass", 64'(cdb_valid), 64'd0);
        tick();
        check("single_valid", 64'(cdb_valid), 64'd1);
        check("single_src", 64'(cdb_src), 64'd2);
        tick();
        check("single_valid_drop", 64'(cdb_valid), 64'd0);
        drain("single_drained", 5);

        // Second burst resumes at rr_ptr=3: 3,4,0,1,2
        burst(32'h200);
        sb_push(3, mk(5'd4, 32'h203));
        sb_push(4, mk(5'd5, 32'h204));
        sb_push(0, mk(5'd1, 32'h200));
        sb_push(1, mk(5'd2, 32'h201));
        sb_push(2, mk(5'd3, 32'h202));
        tick();
        fu_req_valid = '0;
        for (int k = 0; k < N; k++) begin
            tick();
            check("burst2_consec_valid", 64'(cdb_valid), 64'd1);
        end
        drain("burst2_drained", 10);

        // Back-pressure on FU0 with the bus held
        cdb_hold = 1'b1;
        sb_push(0, mk(5'd7, 32'hA));
        sb_push(0, mk(5'd7, 32'hB));
        sb_push(0, mk(5'd7, 32'hC));
        fu_req_valid[0] = 1'b1;
        fu_req_data[0]  = mk(5'd7, 32'hA);
        check("bp_ready_a", 64'(fu_req_ready[0]), 64'd1);
        tick();
        fu_req_data[0] = mk(5'd7, 32'hB);
        check("bp_ready_b", 64'(fu_req_ready[0]), 64'd1);
        tick();
        fu_req_data[0] = mk(5'd7, 32'hC);
        for (int k = 0; k < 3; k++) begin
            check("bp_ready_full", 64'(fu_req_ready[0]), 64'd0);
            check("bp_hold_valid", 64'(cdb_valid), 64'd0);
            tick();
        end
        cdb_hold = 1'b0;
        accepted = 1'b0;
        for (int k = 0; k < 6 && !accepted; k++) begin
            if (fu_req_ready[0]) accepted = 1'b1;
            tick();
        end
        fu_req_valid[0] = 1'b0;
        check("bp_c_accepted", 64'(accepted), 64'd1);
        drain("bp_drained", 10);

        // Burst from rr_ptr=1: FU0 starves after three losses and jumps FU4
        burst(32'h400);
        sb_push(1, mk(5'd2, 32'h401));
        sb_push(2, mk(5'd3, 32'h402));
        sb_push(3, mk(5'd4, 32'h403));
        sb_push(0, mk(5'd1, 32'h400));
        sb_push(4, mk(5'd5, 32'h404));
        tick();
        fu_req_valid = '0;
        drain("burst3_drained", 12);

        // Starvation: FU0/FU1 streaming, FU4 single push, rr_ptr=0
        sb_push(0, mk(5'd1, 32'hA0));
        sb_push(1, mk(5'd2, 32'hB0));
        sb_push(4, mk(5'd3, 32'hD0));
        sb_push(0, mk(5'd1, 32'hA1));
        sb_push(1, mk(5'd2, 32'hB1));
        sb_push(0, mk(5'd1, 32'hA2));
        sb_push(1, mk(5'd2, 32'hB2));
        a_n = 0;
        b_n = 0;
        for (int c = 0; c < 4; c++) begin
            fu_req_valid[0] = 1'b1;
            fu_req_data[0]  = mk(5'd1, 32'hA0 + 32'(a_n));
            fu_req_valid[1] = 1'b1;
            fu_req_data[1]  = mk(5'd2, 32'hB0 + 32'(b_n));
            fu_req_valid[4] = (c == 0);
            fu_req_data[4]  = mk(5'd3, 32'hD0);
            acc0 = fu_req_ready[0];
            acc1 = fu_req_ready[1];
            tick();
            if (acc0) a_n++;
            if (acc1) b_n++;
        end
        fu_req_valid = '0;
        check("starve_fu0_accepts", 64'(a_n), 64'd3);
        check("starve_fu1_accepts", 64'(b_n), 64'd3);
        drain("starve_drained", 12);

        // Hold freeze: FU3 loses twice, then hold for 5 cycles
        fu_req_valid[3] = 1'b1;
        fu_req_data[3]  = mk(5'd4, 32'h300);
        sb_push(3, mk(5'd4, 32'h300));
        tick();
        fu_req_valid = '0;
        drain("hf_pre_drained", 5);
        fu_req_valid[0] = 1'b1;
        fu_req_data[0]  = mk(5'd5, 32'h310);
        fu_req_valid[3] = 1'b1;
        fu_req_data[3]  = mk(5'd6, 32'h331);
        fu_req_valid[4] = 1'b1;
        fu_req_data[4]  = mk(5'd7, 32'h340);
        sb_push(4, mk(5'd7, 32'h340));
        sb_push(0, mk(5'd5, 32'h310));
        sb_push(3, mk(5'd6, 32'h331));
        tick();
        fu_req_valid = '0;
        tick();
        tick();
        cdb_hold = 1'b1;
        check("hf_wait_before", 64'(dut.g_fu[3].u_queue.wait_cnt), 64'd2);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hf_hold_valid", 64'(cdb_valid), 64'd0);
            check("hf_wait_frozen", 64'(dut.g_fu[3].u_queue.wait_cnt), 64'd2);
        end
        cdb_hold = 1'b0;
        drain("hf_drained", 6);

        // Reset mid-stream with two entries queued in FU1
        cdb_hold = 1'b1;
        fu_req_valid[1] = 1'b1;
        fu_req_data[1]  = mk(5'd8, 32'h500);
        fu_req_valid[0] = 1'b1;
        fu_req_data[0]  = mk(5'd9, 32'h600);
        sb_push(0, mk(5'd9, 32'h600));
        tick();
        fu_req_valid[0] = 1'b0;
        fu_req_data[1]  = mk(5'd8, 32'h501);
        tick();
        fu_req_valid[1] = 1'b0;
        cdb_hold = 1'b0;
        tick();
        cdb_hold = 1'b1;
        check("mr_pre_valid", 64'(cdb_valid), 64'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_async_valid", 64'(cdb_valid), 64'd0);
        check("mr_ready_low", 64'(fu_req_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mr_ready_rel", 64'(fu_req_ready), 64'h1f);
        cdb_hold = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check("mr_no_stale_pending", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cdb_writeback_scheduler.md
# cdb_writeback_scheduler

- Buffers completion results from all functional units and schedules them onto the single Common Data Bus.
- Each FU gets a small completion queue with valid/ready back-pressure, so an FU that loses arbitration does not have to hold its result stage.
- Heads are arbitrated round-robin, with a starvation override.
- Sits between the FU result ports and the scoreboard/FU CDB snoop inputs.

## Interface
Parameters:
- NUM_FU, default TOTAL_FU: number of completing functional units.
- QDEPTH, default 2: entries per FU completion queue; power of two, ≥2.
- STARVE_LIMIT, default 8: cycles a queue head may wait before it gets forced priority; 1..255.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- fu_req_valid[NUM_FU]  in  1 each  FU presents a completion.
- fu_req_data[NUM_FU]  in  cdb_entry_t each  completion payload.
- fu_req_ready[NUM_FU]  out  1 each  queue can accept. A transfer occurs on an edge where valid && ready.
- cdb_hold  in  1  scoreboard stalls broadcast this cycle; no pop occurs.
- cdb_valid  out  1  registered; CDB carries a result this cycle.
- cdb_data  out  cdb_entry_t  registered broadcast payload.
- cdb_src  out  $clog2(NUM_FU)  registered index of the FU whose entry is broadcast.

## Operation
- **Per-FU queue.** A FIFO of QDEPTH entries with wrap-around read and write pointers and a count.
  - fu_req_ready = (count < QDEPTH) && rst_n; it does not look ahead to a same-cycle pop.
  - Push and pop on the same edge are legal when count is between 1 and QDEPTH−1; the count is unchanged.
- **Candidates.** Every non-empty queue head is a candidate each cycle in which cdb_hold=0.
- **Starvation override.** Each queue has a wait counter.
  - It increments (saturating at STARVE_LIMIT) every cycle its head is a candidate and is not granted.
  - It clears when the head pops or the queue is empty, and freezes while cdb_hold=1.
  - If any counter equals STARVE_LIMIT, the lowest-index such FU wins.
- **Round-robin.** Otherwise the first candidate at or after rr_ptr (modulo NUM_FU) wins.
  - rr_ptr ← winner+1 (mod NUM_FU) on every grant.
  - rr_ptr is unchanged when there is no grant.
- **Grant.** The winner's head pops on the edge. On that same edge cdb_valid←1, cdb_data←head, cdb_src←winner.
- **No grant.** With no candidate, or cdb_hold=1: cdb_valid←0, while cdb_data and cdb_src hold their values.
- **Ordering.** Each FU's results appear on the CDB in that FU's issue order. There is no ordering across FUs.

## Timing
- **Reset.** While rst_n is low:
  - All queues empty, wait counters 0, rr_ptr 0.
  - cdb_valid 0, cdb_data '0, cdb_src 0.
  - All fu_req_ready 0.
  - On release, ready rises in the same cycle (count=0).
- **Latency.** A result accepted at edge k, uncontended and not held, is popped at edge k+1 and is visible on cdb_valid/cdb_data during the cycle after edge k+1. No bypass.
- **Throughput.** One broadcast per cycle. A single FU can sustain one completion per cycle when QDEPTH ≥ 2.
- **Bounded wait.** A queue head is broadcast within STARVE_LIMIT + NUM_FU cycles of becoming head, excluding hold cycles.
- **Asynchronous reset mid-operation.** All queued entries are discarded immediately and cdb_valid drops asynchronously. A result accepted in the final cycle before reset is lost by design; the scoreboard resets at the same time.
- **Simultaneous events.** Several FUs becoming candidates in the same cycle are resolved within that cycle, and exactly one pops. Pushes to the other queues proceed independently.

## Structure
- cdb_entry_t and TOTAL_FU stay in rv32i_types.
- Add CDB_QDEPTH and CDB_STARVE_LIMIT as package localparams; they supply the defaults.
- Sub-module cdb_fu_queue holds the per-FU FIFO and its wait counter, with ports push/pop/full/empty/head/starved. It is instantiated NUM_FU times via generate.
- The top level contains only the arbiter, rr_ptr and the output registers.

## Test plan
- **Single FU uncontended.** FU2 valid one cycle with rd=5, value 0x1234 at edge 10 → cdb_valid high in the cycle after edge 11 with cdb_src=2 and that payload; cdb_valid low the next cycle.
- **All-FU burst.** All FUs push simultaneously, rr_ptr=0 → broadcasts on consecutive cycles in order 0,1,…,NUM_FU−1; a second simultaneous burst resumes at rr_ptr and follows the same fair rotation.
- **Back-pressure.** Hold cdb_hold=1 while FU0 pushes 3 times with QDEPTH=2 → fu_req_ready[0] falls after 2 accepts and the third is held off; release hold → broadcasts A, B, then C in order.
- **Starvation.** STARVE_LIMIT=3, FU0 and FU1 pushing every cycle, FU4 single push → FU4 broadcast no later than the 4th arbitration after it became head, and before the round-robin would otherwise reach it under the forced pattern.
- **Hold freeze.** FU3 head waiting 2 cycles, then cdb_hold=1 for 5 cycles → no pop, wait counter stays at 2, cdb_valid 0 throughout.
- **Reset mid-stream.** rst_n low for 1 cycle with 2 entries queued in FU1 → cdb_valid 0 immediately; after release no stale entry is broadcast and fu_req_ready is all 1.
